// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - sync word and transmitter state shared by both ends of the sync-word link
package seq_pkg;

  localparam logic [7:0] SYNC_WORD = 8'hD9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    PAYLOAD = 2'd2,
    GAP     = 2'd3
  } tx_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// rtl/piso_shreg.sv - parallel-load, MSB-first shift register; vacated bits refill with FILL
module piso_shreg #(
  parameter int   W    = 8,
  parameter logic FILL = 1'b0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_data,
  output logic         o_msb
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= {W{FILL}};
    end else if (i_load) begin
      r_q <= i_data;
    end else if (i_shift) begin
      r_q <= (r_q << 1) | W'(FILL);
    end
  end

  assign o_msb = r_q[W-1];

endmodule

// File: rtl/seq_frame_tx.sv
// rtl/seq_frame_tx.sv - serial frame transmitter: sync word, MSB-first payload, idle gap
module seq_frame_tx #(
  parameter logic [7:0] SYNC_WORD  = seq_pkg::SYNC_WORD,
  parameter int         PAYLOAD_W  = 8,
  parameter int         GAP_CYCLES = 2,
  parameter logic       IDLE_BIT   = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_in_valid,
  input  logic [PAYLOAD_W-1:0] i_in_data,
  output logic                 o_in_ready,
  output logic                 o_serial_out,
  output logic                 o_tx_active,
  output logic                 o_frame_done
);
  import seq_pkg::*;

  localparam int SR_W  = (PAYLOAD_W > 8) ? PAYLOAD_W : 8;
  localparam int CNT_W = $clog2(max3(8, PAYLOAD_W, GAP_CYCLES) + 1);
  localparam logic [CNT_W-1:0] SYNC_LD = CNT_W'(7);
  localparam logic [CNT_W-1:0] PAY_LD  = CNT_W'(PAYLOAD_W - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  tx_state_t            r_state;
  tx_state_t            w_next_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_next_cnt;
  logic [PAYLOAD_W-1:0] r_hold;
  logic                 r_tx_active;
  logic                 r_frame_done;
  logic                 w_accept;
  logic                 w_cnt_zero;
  logic                 w_load;
  logic                 w_shift;
  logic [SR_W-1:0]      w_load_data;

  assign w_cnt_zero = (r_cnt == '0);
  assign w_accept   = i_in_valid && (r_state == IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Each state is entered with its length minus one; leaving happens at zero.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = w_cnt_zero ? '0 : r_cnt - 1'b1;
    case (r_state)
      IDLE: begin
        if (i_in_valid) begin
          w_next_state = SYNC;
          w_next_cnt   = SYNC_LD;
        end
      end
      SYNC: begin
        if (w_cnt_zero) begin
          w_next_state = PAYLOAD;
          w_next_cnt   = PAY_LD;
        end
      end
      PAYLOAD: begin
        if (w_cnt_zero) begin
          if (GAP_CYCLES == 0) begin
            w_next_state = IDLE;
            w_next_cnt   = '0;
          end else begin
            w_next_state = GAP;
            w_next_cnt   = GAP_LD;
          end
        end
      end
      GAP: begin
        if (w_cnt_zero) begin
          w_next_state = IDLE;
          w_next_cnt   = '0;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  // The shifter is reloaded with the held payload on the last sync bit.
  always_comb begin
    o_in_ready  = (r_state == IDLE);
    w_load      = w_accept || ((r_state == SYNC) && w_cnt_zero);
    w_shift     = ((r_state == SYNC) || (r_state == PAYLOAD)) && !w_load;
    w_load_data = {SR_W{IDLE_BIT}};
    if (r_state == IDLE) begin
      w_load_data[SR_W-1 -: 8] = SYNC_WORD;
    end else begin
      w_load_data[SR_W-1 -: PAYLOAD_W] = r_hold;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold       <= '0;
      r_tx_active  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hold <= i_in_data;
      end
      r_tx_active  <= (w_next_state == SYNC) || (w_next_state == PAYLOAD);
      r_frame_done <= (w_next_state == PAYLOAD) && (w_next_cnt == '0);
    end
  end

  piso_shreg #(
    .W    (SR_W),
    .FILL (IDLE_BIT)
  ) u_piso (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (w_load_data),
    .o_msb   (o_serial_out)
  );

  assign o_tx_active  = r_tx_active;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_seq_frame_tx.sv
// tb/tb_seq_frame_tx.sv - scoreboard bench for seq_frame_tx, default and 1-bit/no-gap instances
module tb_seq_frame_tx;

  typedef struct packed {
    logic ser;
    logic act;
    logic fd;
    logic rdy;
    logic det;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       v0 = 1'b0;
  logic [7:0] d0 = 8'h00;
  logic       rdy0, ser0, act0, fd0;
  logic       v1 = 1'b0;
  logic [0:0] d1 = 1'b0;
  logic       rdy1, ser1, act1, fd1;

  exp_t q0[$];
  exp_t q1[$];
  int   nt = 0;
  int   nf = 0;
  int   cyc = 0;
  int   hs = 0;
  int   hs_b = 0;
  int   hs_diff = 0;
  bit   done = 1'b0;

  logic [7:0] det_sr;
  logic       det;

  always #5 clk = ~clk;

  seq_frame_tx u_dut0 (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_in_valid   (v0),
    .i_in_data    (d0),
    .o_in_ready   (rdy0),
    .o_serial_out (ser0),
    .o_tx_active  (act0),
    .o_frame_done (fd0)
  );

  seq_frame_tx #(.PAYLOAD_W(1), .GAP_CYCLES(0)) u_dut1 (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_in_valid   (v1),
    .i_in_data    (d1),
    .o_in_ready   (rdy1),
    .o_serial_out (ser1),
    .o_tx_active  (act1),
    .o_frame_done (fd1)
  );

  // Reference sync-word detector fed from the serial line.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) det_sr <= 8'h00;
    else        det_sr <= {det_sr[6:0], ser0};
  end
  assign det = (det_sr == 8'hD9);

  always @(posedge clk) begin
    if (v0 && rdy0) hs <= hs + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle0(input int n);
    v0 = 1'b0;
    for (int i = 0; i < n; i++) begin
      q0.push_back('{ser: 1'b0, act: 1'b0, fd: 1'b0, rdy: 1'b1, det: 1'b0});
      step();
    end
  endtask

  task automatic frame0(input logic [7:0] data, input logic bv, input logic [7:0] bd,
                        input int abort_at);
    logic [15:0] bits;
    bits = {8'hD9, data};
    v0 = 1'b1;
    d0 = data;
    q0.push_back('{ser: 1'b0, act: 1'b0, fd: 1'b0, rdy: 1'b1, det: 1'b0});
    step();
    for (int c = 1; c <= 18; c++) begin
      v0 = bv;
      d0 = bd;
      if (c == abort_at) begin
        v0    = 1'b0;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
          q0.push_back('{ser: 1'b0, act: 1'b0, fd: 1'b0, rdy: 1'b1, det: 1'b0});
          step();
        end
        rst_n = 1'b1;
        return;
      end
      if (c <= 16) begin
        q0.push_back('{ser: bits[16-c], act: 1'b1, fd: (c == 16), rdy: 1'b0, det: (c == 9)});
      end else begin
        q0.push_back('{ser: 1'b0, act: 1'b0, fd: 1'b0, rdy: 1'b0, det: 1'b0});
      end
      step();
    end
  endtask

  task automatic frame1(input logic data);
    logic [8:0] bits;
    bits = {8'hD9, data};
    v1 = 1'b1;
    d1 = data;
    q1.push_back('{ser: 1'b0, act: 1'b0, fd: 1'b0, rdy: 1'b1, det: 1'b0});
    step();
    v1 = 1'b0;
    d1 = ~data;
    for (int c = 1; c <= 9; c++) begin
      q1.push_back('{ser: bits[9-c], act: 1'b1, fd: (c == 9), rdy: 1'b0, det: 1'b0});
      step();
    end
    q1.push_back('{ser: 1'b0, act: 1'b0, fd: 1'b0, rdy: 1'b1, det: 1'b0});
    step();
  endtask

  initial begin
    step();
    for (int i = 0; i < 3; i++) begin
      q0.push_back('{ser: 1'b0, act: 1'b0, fd: 1'b0, rdy: 1'b1, det: 1'b0});
      step();
    end
    rst_n = 1'b1;
    idle0(20);
    frame0(8'hA5, 1'b0, 8'h5A, 0);
    idle0(2);
    frame0(8'h3C, 1'b0, 8'hC3, 0);
    idle0(2);
    hs_b = hs;
    frame0(8'h00, 1'b1, 8'hFF, 0);
    frame0(8'hFF, 1'b0, 8'h00, 0);
    idle0(3);
    hs_diff = hs - hs_b;
    frame0(8'hA5, 1'b0, 8'hA5, 12);
    frame0(8'h5A, 1'b0, 8'h00, 0);
    idle0(2);
    frame1(1'b1);
    frame1(1'b0);
    done = 1'b1;
  end

  initial begin
    exp_t e;
    exp_t g;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        g = '{ser: ser0, act: act0, fd: fd0, rdy: rdy0, det: det};
        nt++;
        if (g !== e) begin
          nf++;
          $display("FAIL dut0 cycle %0d: ser/act/fd/rdy/det got %b required %b", cyc, g, e);
        end
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        g = '{ser: ser1, act: act1, fd: fd1, rdy: rdy1, det: 1'b0};
        nt++;
        if (g !== e) begin
          nf++;
          $display("FAIL dut1 cycle %0d: ser/act/fd/rdy got %b required %b", cyc, g[4:1], e[4:1]);
        end
      end
      if (done) begin
        nt++;
        if (hs_diff != 2) begin
          nf++;
          $display("FAIL back_to_back_handshakes: got %0d required 2", hs_diff);
        end
        $display("[TB] %0d tests run, %0d failed", nt, nf);
        $finish;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete, got timeout required finish");
    $fatal(1);
  end

endmodule
